// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, interrupt request and eret handling for the MIPS core.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_unit #(
    parameter logic [31:0] PRID        = 32'h4D49_5053,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [29:0] PC,
    input  logic        BD,
    input  logic [5:0]  HWInt,
    input  logic        eret,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    localparam int unsigned IP_W      = 6;
    localparam int unsigned EXC_W     = 5;
    localparam int unsigned LAST_SYNC = SYNC_STAGES - 1;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    generate
        if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("cp0_unit: SYNC_STAGES must be 1..3");
        end
    endgenerate

    logic [IP_W-1:0]  r_im;
    logic             r_exl;
    logic             r_ie;
    logic             r_bd;
    logic [EXC_W-1:0] r_exc;
    logic [29:0]      r_epc;
    // Last stage of the chain is Cause.IP itself.
    logic [IP_W-1:0]  r_sync [SYNC_STAGES];

    logic [IP_W-1:0]  w_ip;
    logic             w_int_req;
    logic             w_wr;
    logic [31:0]      w_dout;

    assign w_int_req = (|(w_ip & r_im)) & r_ie & ~r_exl;
    assign w_wr      = We & ~w_int_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= HWInt;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // SR: interrupt entry beats everything; eret clears EXL after any same-cycle mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
        end else if (w_int_req) begin
            r_exl <= 1'b1;
        end else if (w_wr && A2 == REG_SR) begin
            r_im  <= DIn[15:10];
            r_ie  <= DIn[0];
            r_exl <= eret ? 1'b0 : DIn[1];
        end else if (eret) begin
            r_exl <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc <= '0;
            r_bd  <= 1'b0;
            r_exc <= '0;
        end else if (w_int_req) begin
            r_epc <= BD ? (PC - 30'd1) : PC;
            r_bd  <= BD;
            r_exc <= '0;
        end else if (w_wr && A2 == REG_EPC) begin
            r_epc <= DIn[31:2];
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr && A2 == REG_COUNT) begin
                r_count <= DIn;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (w_wr && A2 == REG_COMPARE) begin
                r_compare <= DIn;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ip = {r_sync[LAST_SYNC][5] | r_ti, r_sync[LAST_SYNC][4:0]};
`else
    assign w_ip = r_sync[LAST_SYNC];
`endif

    // mfc0 read mux, pre-edge state only.
    always_comb begin
        w_dout = '0;
        case (A1)
            REG_SR:    w_dout = {16'b0, r_im, 8'b0, r_exl, r_ie};
            REG_CAUSE: w_dout = {r_bd, 15'b0, w_ip, 3'b0, r_exc, 2'b0};
            REG_EPC:   w_dout = {r_epc, 2'b00};
            REG_PRID:  w_dout = PRID;
`ifdef CP0_TIMER_EN
            REG_COUNT:   w_dout = r_count;
            REG_COMPARE: w_dout = r_compare;
`endif
            default:   w_dout = '0;
        endcase
    end

    assign IntReq = w_int_req;
    assign EPC    = r_epc;
    assign DOut   = w_dout;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: stimulus pushes expectations, a monitor pops and compares.
module tb_cp0_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [29:0] PC;
    logic        BD;
    logic [5:0]  HWInt;
    logic        eret;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    cp0_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A1     (A1),
        .A2     (A2),
        .DIn    (DIn),
        .We     (We),
        .PC     (PC),
        .BD     (BD),
        .HWInt  (HWInt),
        .eret   (eret),
        .IntReq (IntReq),
        .EPC    (EPC),
        .DOut   (DOut)
    );

`ifdef CP0_TIMER_EN
    localparam logic [31:0] TIB = 32'h0000_8000;
`else
    localparam logic [31:0] TIB = 32'h0000_0000;
`endif

    typedef struct {
        string       name;
        logic [31:0] dout;
        logic        irq;
        logic [29:0] epc;
    } exp_t;

    exp_t exp_q[$];
    event ev_chk;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Monitor: compares every sampled output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(ev_chk);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL monitor: sample with empty scoreboard");
            end else begin
                e = exp_q.pop_front();
                if (DOut !== e.dout) begin
                    bad++;
                    $display("FAIL %s dout got %08h want %08h", e.name, DOut, e.dout);
                end
                total++;
                if (IntReq !== e.irq) begin
                    bad++;
                    $display("FAIL %s intreq got %0b want %0b", e.name, IntReq, e.irq);
                end
                total++;
                if (EPC !== e.epc) begin
                    bad++;
                    $display("FAIL %s epc got %08h want %08h", e.name, EPC, e.epc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] a1, input logic [31:0] d,
                       input logic irq, input logic [29:0] epc);
        exp_t e;
        A1 = a1;
        #1;
        e.name = nm;
        e.dout = d;
        e.irq  = irq;
        e.epc  = epc;
        exp_q.push_back(e);
        -> ev_chk;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a2, input logic [31:0] d);
        We  = 1'b1;
        A2  = a2;
        DIn = d;
    endtask

    initial begin
        rst_n = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = '0; We = 1'b0;
        PC = '0; BD = 1'b0; HWInt = '0; eret = 1'b0;
        #2;
        chk("rst_sr",    5'd12, 32'h0, 1'b0, 30'h0);
        chk("rst_cause", 5'd13, 32'h0, 1'b0, 30'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Basic interrupt with two-stage synchronizer latency
        mtc0(5'd12, 32'h0000_0401); tick(); We = 1'b0;
        HWInt = 6'b000001; PC = 30'h0C01;
        tick(); chk("sync1",    5'd13, TIB, 1'b0, 30'h0);
        tick(); chk("irq_rise", 5'd13, 32'h400 | TIB, 1'b1, 30'h0);
        tick();
        chk("take_cause", 5'd13, 32'h400 | TIB, 1'b0, 30'h0C01);
        chk("take_sr",    5'd12, 32'h403, 1'b0, 30'h0C01);
        chk("take_epc",   5'd14, 32'h3004, 1'b0, 30'h0C01);

        // Masked while EXL=1, fires after eret; then delay-slot entry
        tick(); tick(); chk("masked", 5'd12, 32'h403, 1'b0, 30'h0C01);
        eret = 1'b1; PC = 30'h0C02; BD = 1'b1;
        tick(); eret = 1'b0;
        chk("eret_irq", 5'd12, 32'h401, 1'b1, 30'h0C01);
        tick();
        chk("ds_cause", 5'd13, 32'h8000_0400 | TIB, 1'b0, 30'h0C01);
        chk("ds_epc",   5'd14, 32'h3004, 1'b0, 30'h0C01);

        // Interrupt beats same-cycle mtc0 to EPC
        eret = 1'b1; BD = 1'b0; PC = 30'h1234;
        tick(); eret = 1'b0;
        chk("eret2", 5'd12, 32'h401, 1'b1, 30'h0C01);
        mtc0(5'd14, 32'hDEAD_BEEC); tick(); We = 1'b0;
        chk("prio_epc",   5'd14, 32'h48D0, 1'b0, 30'h1234);
        chk("prio_cause", 5'd13, 32'h400 | TIB, 1'b0, 30'h1234);

        // eret with mtc0 SR: write lands, then EXL forced low
        HWInt = '0; tick(); tick();
        chk("ip_clr", 5'd13, TIB, 1'b0, 30'h1234);
        eret = 1'b1; mtc0(5'd12, 32'h0000_0403);
        tick(); eret = 1'b0; We = 1'b0;
        chk("eret_mtc0", 5'd12, 32'h401, 1'b0, 30'h1234);

        // No write-to-read bypass; read-only registers; unmapped reads
        mtc0(5'd14, 32'h0000_0100);
        chk("no_bypass", 5'd14, 32'h48D0, 1'b0, 30'h1234);
        tick(); We = 1'b0;
        chk("epc_wr", 5'd14, 32'h100, 1'b0, 30'h40);
        mtc0(5'd13, 32'hFFFF_FFFF); tick();
        mtc0(5'd15, 32'hFFFF_FFFF); tick(); We = 1'b0;
        chk("cause_ro", 5'd13, TIB, 1'b0, 30'h40);
        chk("prid",     5'd15, 32'h4D49_5053, 1'b0, 30'h40);
        chk("unmapped", 5'd3,  32'h0, 1'b0, 30'h40);
`ifndef CP0_TIMER_EN
        mtc0(5'd9, 32'h55); tick();
        mtc0(5'd11, 32'h66); tick(); We = 1'b0;
        chk("no_count",   5'd9,  32'h0, 1'b0, 30'h40);
        chk("no_compare", 5'd11, 32'h0, 1'b0, 30'h40);
`endif

        // EPC wrap-around for a delay-slot instruction at PC=0
        HWInt = 6'b000001; tick();
        BD = 1'b1; PC = 30'h0;
        tick(); chk("wrap_irq", 5'd13, 32'h400 | TIB, 1'b1, 30'h40);
        tick(); chk("wrap_epc", 5'd14, 32'hFFFF_FFFC, 1'b0, 30'h3FFF_FFFF);

        // Async reset mid-handler, pending line re-synchronized
        #10; rst_n = 1'b0; #1;
        chk("mr_sr",    5'd12, 32'h0, 1'b0, 30'h0);
        chk("mr_cause", 5'd13, 32'h0, 1'b0, 30'h0);
        BD = 1'b0; mtc0(5'd12, 32'h0000_0401);
        rst_n = 1'b1;
        tick(); We = 1'b0;
        chk("mr_sync", 5'd13, TIB, 1'b0, 30'h0);
        tick(); chk("mr_irq", 5'd13, 32'h400 | TIB, 1'b1, 30'h0);

`ifdef CP0_TIMER_EN
        // Timer: Compare=5, Count=0, SR enables IM[15]
        HWInt = '0; rst_n = 1'b0; #1; rst_n = 1'b1;
        mtc0(5'd11, 32'd5); tick();
        mtc0(5'd9, 32'd0); tick();
        mtc0(5'd12, 32'h0000_8001); tick(); We = 1'b0;
        chk("cnt", 5'd9, 32'd1, 1'b0, 30'h0);
        PC = 30'h2000;
        tick(); tick(); tick(); tick();
        chk("pre_ti", 5'd9, 32'd5, 1'b0, 30'h0);
        tick(); chk("ti_irq",  5'd13, 32'h8000, 1'b1, 30'h0);
        tick(); chk("ti_take", 5'd13, 32'h8000, 1'b0, 30'h2000);
        mtc0(5'd11, 32'h100); tick(); We = 1'b0;
        chk("ti_clr", 5'd13, 32'h0, 1'b0, 30'h2000);
        chk("ti_cmp", 5'd11, 32'h100, 1'b0, 30'h2000);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("ti_eret", 5'd12, 32'h8001, 1'b0, 30'h2000);
`endif

        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
